// File: rtl/pe_irq_ctrl.sv
// Interrupt request controller wrapped around an external 4:2 priority encoder.
// Registers, edge-detects and masks request lines, then holds the encoded request until ack or timeout.
module pe_irq_ctrl #(
    parameter logic [3:0]  EDGE_MASK = 4'b0000,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_irq_in,
    input  logic [3:0] i_mask,
    output logic       o_a0,
    output logic       o_a1,
    output logic       o_a2,
    output logic       o_a3,
    input  logic       i_y0,
    input  logic       i_y1,
    input  logic       i_v,
    output logic       o_irq_req,
    output logic [1:0] o_irq_vec,
    input  logic       i_irq_ack,
    output logic       o_timeout_err,
    output logic [3:0] o_pending
);

    typedef enum logic [1:0] {StIdle, StReq, StGap} state_t;

    localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

    state_t     r_state, w_state_d;
    logic [3:0] r_pending, w_pending_d;
    logic [3:0] r_irq_in_d;
    logic       r_irq_req, w_irq_req_d;
    logic [1:0] r_irq_vec, w_irq_vec_d;
    logic       r_timeout_err, w_timeout_err_d;
    logic [7:0] r_timer, w_timer_d;
    logic [3:0] w_rise;
    logic [3:0] w_ack_clr;
    logic [3:0] w_a;

    assign w_rise = i_irq_in & ~r_irq_in_d;

    // A new rising edge beats an ack-clear on the same bit.
    always_comb begin
        w_ack_clr   = '0;
        w_pending_d = '0;
        if (r_state == StReq && i_irq_ack) begin
            w_ack_clr[r_irq_vec] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            if (EDGE_MASK[i]) begin
                w_pending_d[i] = w_rise[i] | (r_pending[i] & ~w_ack_clr[i]);
            end else begin
                w_pending_d[i] = i_irq_in[i];
            end
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_irq_req_d     = r_irq_req;
        w_irq_vec_d     = r_irq_vec;
        w_timeout_err_d = 1'b0;
        w_timer_d       = r_timer;
        unique case (r_state)
            StIdle: begin
                if (i_v) begin
                    w_irq_vec_d = {i_y1, i_y0};
                    w_irq_req_d = 1'b1;
                    w_timer_d   = '0;
                    w_state_d   = StReq;
                end
            end
            StReq: begin
                if (i_irq_ack) begin
                    w_irq_req_d = 1'b0;
                    w_state_d   = StGap;
                end else if (r_timer == TimerLast) begin
                    w_irq_req_d     = 1'b0;
                    w_timeout_err_d = 1'b1;
                    w_state_d       = StGap;
                end else begin
                    w_timer_d = r_timer + 8'd1;
                end
            end
            StGap: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_pending     <= '0;
            r_irq_in_d    <= '0;
            r_irq_req     <= 1'b0;
            r_irq_vec     <= '0;
            r_timeout_err <= 1'b0;
            r_timer       <= '0;
        end else begin
            r_state       <= w_state_d;
            r_pending     <= w_pending_d;
            r_irq_in_d    <= i_irq_in;
            r_irq_req     <= w_irq_req_d;
            r_irq_vec     <= w_irq_vec_d;
            r_timeout_err <= w_timeout_err_d;
            r_timer       <= w_timer_d;
        end
    end

    assign w_a           = r_pending & ~i_mask;
    assign o_a0          = w_a[0];
    assign o_a1          = w_a[1];
    assign o_a2          = w_a[2];
    assign o_a3          = w_a[3];
    assign o_irq_req     = r_irq_req;
    assign o_irq_vec     = r_irq_vec;
    assign o_timeout_err = r_timeout_err;
    assign o_pending     = r_pending;

endmodule
